serial_descrambler: RTL and testbench

SERIAL_DESCRAMBLER -- requirements
Module: serial_descrambler

---
 rtl/scrambler_pkg.sv | 31 +++
 rtl/scr_hist_shift.sv | 23 ++
 rtl/serial_scrambler.sv | 57 +++++
 rtl/serial_descrambler.sv | 114 +++++++++++
 tb/tb_serial_descrambler.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/scrambler_pkg.sv
// Shared definitions for the additive x^DEGREE + x^TAP + 1 scrambler pair.
package scrambler_pkg;

    localparam int DEGREE_DEFAULT = 7;
    localparam int TAP_DEFAULT    = 6;

    // History vectors are zero-extended to this width before being handed
    // to the tap function, so one function serves every DEGREE.
    localparam int MAX_DEGREE     = 32;

    typedef enum logic {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } sync_state_t;

    // Self-synchronising tap combination. The scrambler and the descrambler
    // use the same expression; only what gets shifted into the history differs.
    function automatic logic mix_bit(
        input logic                  s,
        input logic [MAX_DEGREE-1:0] hist,
        input int                    degree,
        input int                    tap
    );
        logic [4:0] tap_idx;
        logic [4:0] deg_idx;
        tap_idx = 5'(tap - 1);
        deg_idx = 5'(degree - 1);
        return s ^ hist[tap_idx] ^ hist[deg_idx];
    endfunction

endpackage

// File: rtl/scr_hist_shift.sv
// DEGREE-bit history shift register; hist[0] is the most recent bit.
module scr_hist_shift
    import scrambler_pkg::*;
#(
    parameter int DEGREE = DEGREE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    output logic [DEGREE-1:0] hist
);

    // Shift in one bit per enabled cycle, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (en) begin
            hist <= {hist[DEGREE-2:0], din};
        end
    end

endmodule

// File: rtl/serial_scrambler.sv
// Companion self-synchronising scrambler with a single output register and
// valid/ready handshakes on both sides. The history holds scrambled bits.
module serial_scrambler
    import scrambler_pkg::*;
#(
    parameter int DEGREE = DEGREE_DEFAULT,
    parameter int TAP    = TAP_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic up_valid,
    input  logic up_data,
    output logic up_ready,
    output logic down_valid,
    output logic down_data,
    input  logic down_ready
);

    logic                  in_xfer;
    logic                  out_xfer;
    logic                  scr_bit;
    logic [DEGREE-1:0]     hist;
    logic [MAX_DEGREE-1:0] hist_ext;

    assign up_ready = !down_valid || down_ready;
    assign in_xfer  = up_valid && up_ready;
    assign out_xfer = down_valid && down_ready;

    // Widen the history for the shared tap function.
    always_comb begin
        hist_ext               = '0;
        hist_ext[DEGREE-1:0]   = hist;
        scr_bit                = mix_bit(up_data, hist_ext, DEGREE, TAP);
    end

    scr_hist_shift #(.DEGREE(DEGREE)) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_xfer),
        .din   (scr_bit),
        .hist  (hist)
    );

    // Output register: load on accept, empty on a drain with no refill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            down_valid <= 1'b0;
            down_data  <= 1'b0;
        end else if (in_xfer) begin
            down_valid <= 1'b1;
            down_data  <= scr_bit;
        end else if (out_xfer) begin
            down_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_descrambler.sv
// Self-synchronising descrambler for x^DEGREE + x^TAP + 1. Output bits are
// flagged as locked once DEGREE received bits have filled the history, since
// only then is the descrambled stream independent of the reset state.
module serial_descrambler
    import scrambler_pkg::*;
#(
    parameter int DEGREE = DEGREE_DEFAULT,
    parameter int TAP    = TAP_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic             up_data,
    output logic             up_ready,
    output logic             down_valid,
    output logic             down_data,
    output logic             down_locked,
    input  logic             down_ready,
    output logic [CNT_W-1:0] bit_count
);

    localparam int SC_W = $clog2(DEGREE + 1);

    logic                  in_xfer;
    logic                  out_xfer;
    logic                  plain_bit;
    logic [DEGREE-1:0]     hist;
    logic [MAX_DEGREE-1:0] hist_ext;

    sync_state_t           state;
    sync_state_t           state_nxt;
    logic [SC_W-1:0]       sync_cnt;
    logic [SC_W-1:0]       sync_cnt_nxt;

    assign up_ready = !down_valid || down_ready;
    assign in_xfer  = up_valid && up_ready;
    assign out_xfer = down_valid && down_ready;

    // Widen the history for the shared tap function.
    always_comb begin
        hist_ext             = '0;
        hist_ext[DEGREE-1:0] = hist;
        plain_bit            = mix_bit(up_data, hist_ext, DEGREE, TAP);
    end

    // History holds received (scrambled) bits, which is what makes the
    // descrambler self-synchronising.
    scr_hist_shift #(.DEGREE(DEGREE)) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_xfer),
        .din   (up_data),
        .hist  (hist)
    );

    // Sync FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SYNC;
            sync_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sync_cnt <= sync_cnt_nxt;
        end
    end

    // Count accepted bits until the history is full; LOCKED never leaves.
    always_comb begin
        state_nxt    = state;
        sync_cnt_nxt = sync_cnt;
        case (state)
            SYNC: begin
                if (in_xfer) begin
                    sync_cnt_nxt = sync_cnt + 1'b1;
                    if (sync_cnt_nxt == SC_W'(DEGREE)) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                state_nxt = LOCKED;
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // Output register; the lock flag reflects the state before this bit arrived.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            down_valid  <= 1'b0;
            down_data   <= 1'b0;
            down_locked <= 1'b0;
        end else if (in_xfer) begin
            down_valid  <= 1'b1;
            down_data   <= plain_bit;
            down_locked <= (state == LOCKED);
        end else if (out_xfer) begin
            down_valid  <= 1'b0;
        end
    end

    // Delivered-bit counter, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_count <= '0;
        end else if (out_xfer && (bit_count != '1)) begin
            bit_count <= bit_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_descrambler.sv
// Directed + randomized bench for serial_descrambler, with a queue-based
// reference model, a scrambler loopback and a narrow-counter instance.
module tb_serial_descrambler;

    localparam int DEG  = 7;
    localparam int TP   = 6;
    localparam int CW   = 16;
    localparam int NLB  = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT
    logic          rst_n, up_valid, up_data, up_ready;
    logic          down_valid, down_data, down_locked, down_ready;
    logic [CW-1:0] bit_count;

    serial_descrambler #(.DEGREE(DEG), .TAP(TP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_data(up_data),
        .up_ready(up_ready), .down_valid(down_valid), .down_data(down_data),
        .down_locked(down_locked), .down_ready(down_ready), .bit_count(bit_count)
    );

    // Loopback chain
    logic          lb_rst_n, scr_v, scr_d, scr_ur, mid_v, mid_d, lb_ur;
    logic          lb_dv, lb_dd, lb_dl, lb_dr;
    logic [CW-1:0] lb_cnt;

    serial_scrambler #(.DEGREE(DEG), .TAP(TP)) u_scr (
        .clk(clk), .rst_n(lb_rst_n), .up_valid(scr_v), .up_data(scr_d),
        .up_ready(scr_ur), .down_valid(mid_v), .down_data(mid_d),
        .down_ready(lb_ur)
    );

    serial_descrambler #(.DEGREE(DEG), .TAP(TP), .CNT_W(CW)) u_lb (
        .clk(clk), .rst_n(lb_rst_n), .up_valid(mid_v), .up_data(mid_d),
        .up_ready(lb_ur), .down_valid(lb_dv), .down_data(lb_dd),
        .down_locked(lb_dl), .down_ready(lb_dr), .bit_count(lb_cnt)
    );

    // Narrow counter instance
    logic       c4_rst_n, c4_v, c4_d, c4_ur, c4_dv, c4_dd, c4_dl, c4_r;
    logic [3:0] c4_cnt;

    serial_descrambler #(.DEGREE(DEG), .TAP(TP), .CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(c4_rst_n), .up_valid(c4_v), .up_data(c4_d),
        .up_ready(c4_ur), .down_valid(c4_dv), .down_data(c4_dd),
        .down_locked(c4_dl), .down_ready(c4_r), .bit_count(c4_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic       m_valid, m_data, m_locked;
    int         m_count;
    logic       rx[$];      // every bit accepted since reset, oldest first
    logic       outs[$];    // delivered data bits
    logic       out_lk[$];  // delivered lock flags

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit received k transfers before the next one; zero before reset history.
    function automatic logic past(input int k);
        int n;
        n = rx.size();
        return (n >= k) ? rx[n-k] : 1'b0;
    endfunction

    // One clock of the main DUT: drive, check at negedge, advance the model.
    task automatic cyc(input logic r_n, input logic v, input logic d, input logic r);
        logic in_x, out_x;
        rst_n = r_n; up_valid = v; up_data = d; down_ready = r;
        @(negedge clk);
        chk("up_ready", up_ready, (!m_valid || r) ? 1 : 0);
        chk("down_valid", down_valid, m_valid);
        if (m_valid) begin
            chk("down_data", down_data, m_data);
            chk("down_locked", down_locked, m_locked);
        end
        chk("bit_count", bit_count, m_count);
        @(posedge clk);
        if (!r_n) begin
            m_valid = 0; m_data = 0; m_locked = 0; m_count = 0;
            rx.delete();
        end else begin
            in_x  = v && (!m_valid || r);
            out_x = m_valid && r;
            if (out_x) begin
                if (m_count < (1 << CW) - 1) m_count++;
                outs.push_back(m_data);
                out_lk.push_back(m_locked);
            end
            if (in_x) begin
                m_data   = d ^ past(TP) ^ past(DEG);
                m_locked = (rx.size() >= DEG);
                m_valid  = 1;
                rx.push_back(d);
            end else if (out_x) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [8:0] dir_in, dir_out, dir_lk;
        logic       rb;
        int         n_rx, xf;
        logic       src_q[$];

        m_valid = 0; m_data = 0; m_locked = 0; m_count = 0;
        rst_n = 0; up_valid = 0; up_data = 0; down_ready = 0;
        lb_rst_n = 0; scr_v = 0; scr_d = 0; lb_dr = 0;
        c4_rst_n = 0; c4_v = 0; c4_d = 0; c4_r = 0;

        // Reset, with a transfer attempted during reset
        @(posedge clk); #1;
        cyc(0, 1, 1, 1);
        cyc(0, 0, 0, 0);
        chk("rst_data", down_data, 0);
        chk("rst_locked", down_locked, 0);
        chk("rst_ready", up_ready, 1);

        // Directed impulse: 1 then zeros
        dir_in  = 9'b0_0000_0001;   // bit i fed at step i
        dir_out = 9'b0_1100_0001;
        dir_lk  = 9'b1_1000_0000;
        outs.delete(); out_lk.delete();
        for (int i = 0; i < 9; i++) cyc(1, 1, dir_in[i], 1);
        cyc(1, 0, 0, 1);
        chk("dir_n", outs.size(), 9);
        for (int i = 0; i < 9 && i < outs.size(); i++) begin
            chk("dir_data", outs[i], dir_out[i]);
            chk("dir_lock", out_lk[i], dir_lk[i]);
        end

        // Random valid/ready/data, including junk data while idle
        for (int i = 0; i < 300; i++)
            cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Backpressure: consumer stalled 5 cycles with producer pushing
        for (int i = 0; i < 5; i++) cyc(1, 1, 1'($urandom_range(0, 1)), 0);
        chk("bp_ready", up_ready, 0);
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 1);

        // Full throughput
        xf = m_count;
        for (int i = 0; i < 40; i++) cyc(1, 1, 1'($urandom_range(0, 1)), 1);
        chk("tp_count", bit_count, xf + 39);

        // Reset in the middle of a stream
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1'($urandom_range(0, 1)), 1);
        cyc(0, 1, 1, 1);
        chk("mid_rst_valid", down_valid, 0);
        chk("mid_rst_count", bit_count, 0);
        outs.delete(); out_lk.delete();
        for (int i = 0; i < 12; i++) cyc(1, 1, 1'($urandom_range(0, 1)), 1);
        cyc(1, 0, 0, 1);
        for (int i = 0; i < outs.size(); i++) chk("mid_lock", out_lk[i], (i >= DEG) ? 1 : 0);

        // Loopback through the scrambler
        @(posedge clk); #1;
        lb_rst_n = 1;
        n_rx = 0;
        for (int i = 0; i < 6000 && n_rx < NLB; i++) begin
            scr_v = ($urandom_range(0, 3) != 0);
            scr_d = 1'($urandom_range(0, 1));
            lb_dr = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (scr_v && scr_ur) src_q.push_back(scr_d);
            if (lb_dv && lb_dr) begin
                if (src_q.size() > 0) begin
                    rb = src_q.pop_front();
                    chk("lb_bit", lb_dd, rb);
                end else begin
                    chk("lb_extra", src_q.size(), 1);
                end
                n_rx++;
            end
            @(posedge clk); #1;
        end
        chk("lb_count", n_rx, NLB);
        scr_v = 0; lb_dr = 0;

        // Narrow counter saturation
        c4_rst_n = 1; c4_v = 1; c4_r = 1;
        xf = 0;
        for (int i = 0; i < 24; i++) begin
            c4_d = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("c4_count", c4_cnt, (xf > 15) ? 15 : xf);
            if (c4_dv && c4_r) xf++;
            @(posedge clk); #1;
        end
        chk("c4_xfers", (xf >= 20) ? 1 : 0, 1);
        chk("c4_sat", c4_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
